// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared state encodings for the button front end and button FSM
package button_debounce_pkg;

    // Debounce FSM states; the downstream button FSM relies on these exact encodings
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// rtl/button_debounce_sync_2ff.sv - generic two-flop synchronizer with async active-low reset
module button_debounce_sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_q;

    // Two-stage capture of an asynchronous input; reset value reads as deasserted
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_s1 <= 1'b0;
            r_q  <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_q  <= r_s1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronize and debounce a raw button pin; optional long press via BUTTON_DEBOUNCE_LONG_PRESS_EN
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter int LONG_CYCLES     = 8,
    parameter int LONG_CNT_W      = 24
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button,
    output logic o_btn_db,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_press
);

    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_CNT_W-1:0] LONG_MAX = LONG_CNT_W'(LONG_CYCLES - 1);

    logic             w_btn_s;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_db;
    logic             r_press;
    logic             r_release;

    // The pin is only ever observed through this synchronizer
    button_debounce_sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_button),
        .o_q     (w_btn_s)
    );

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES uninterrupted wait cycles
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_btn_db  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_btn_s) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_btn_s) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state  <= ST_PRESSED;
                        r_cnt    <= '0;
                        r_btn_db <= 1'b1;
                        r_press  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!w_btn_s) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_btn_s) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_btn_db  <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_btn_db        = r_btn_db;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    logic [LONG_CNT_W-1:0] r_long_cnt;
    logic                  r_long_done;
    logic                  r_long;

    // Long-press timer: counts PRESSED cycles, fires once per continuous PRESSED stretch
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_long_cnt  <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (r_state == ST_PRESSED) begin
                if (r_long_cnt == LONG_MAX) begin
                    if (!r_long_done) begin
                        r_long      <= 1'b1;
                        r_long_done <= 1'b1;
                    end
                end else begin
                    r_long_cnt <= r_long_cnt + LONG_CNT_W'(1);
                end
            end else begin
                r_long_cnt  <= '0;
                r_long_done <= 1'b0;
            end
        end
    end

    assign o_long_press = r_long;
`else
    logic w_unused_long;

    // Long-press parameters are intentionally inert without the timer
    assign w_unused_long = ^LONG_MAX;
    assign o_long_press  = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce with a run-length reference model
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 8;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic i_button;
    logic o_btn_db;
    logic o_press_pulse;
    logic o_release_pulse;
    logic o_long_press;

    int checks = 0;
    int errors = 0;
    int n_press = 0;
    int n_rel = 0;
    int n_long = 0;

    // Reference model state
    bit p1 = 0, p2 = 0;
    bit m_db = 0, m_press = 0, m_rel = 0, m_long = 0;
    int m_run = 0;
    int m_streak = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (16),
        .LONG_CYCLES     (L),
        .LONG_CNT_W      (24)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_button        (i_button),
        .o_btn_db        (o_btn_db),
        .o_press_pulse   (o_press_pulse),
        .o_release_pulse (o_release_pulse),
        .o_long_press    (o_long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Model: the level flips once the synchronized pin has disagreed with it for D+1 consecutive
    // edges; any agreeing edge wipes the run. Long press fires on the L-th consecutive edge spent
    // in the settled-pressed condition (level high, no pending disagreement).
    initial begin
        forever begin : model
            bit bs;
            bit was_pressed;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                p1 = 0; p2 = 0;
                m_db = 0; m_run = 0; m_streak = 0;
                m_press = 0; m_rel = 0; m_long = 0;
            end else begin
                bs = p2;
                p2 = p1;
                p1 = i_button;
                was_pressed = m_db && (m_run == 0);
                m_press = 0;
                m_rel = 0;
                if (bs != m_db) begin
                    m_run++;
                    if (m_run == D + 1) begin
                        m_db = bs;
                        m_run = 0;
                        m_press = bs;
                        m_rel = !bs;
                    end
                end else begin
                    m_run = 0;
                end
                m_streak = was_pressed ? m_streak + 1 : 0;
                m_long = LONG_EN && (m_streak == L);
            end
        end
    end

    // Every-cycle comparison against the model, plus pulse tallies for the directed checks
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_btn_db", o_btn_db, m_db);
            chk("cyc_press", o_press_pulse, m_press);
            chk("cyc_release", o_release_pulse, m_rel);
            chk("cyc_long", o_long_press, m_long);
            if (o_press_pulse) n_press++;
            if (o_release_pulse) n_rel++;
            if (o_long_press) n_long++;
        end
    end

    initial begin
        bit bnc [6];
        bnc = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rst_n = 1'b0;
        i_button = 1'b0;
        #3 rst_n = 1'b1;

        // 1: idle after reset
        wait_neg(20);
        chk("idle_db", o_btn_db, 0);
        chk("idle_press_cnt", n_press, 0);
        chk("idle_rel_cnt", n_rel, 0);
        chk("idle_long", o_long_press, 0);

        // 2: clean press held 12 cycles
        n_press = 0; n_rel = 0;
        i_button = 1'b1;
        wait_neg(6);
        chk("press_db_before_e6", o_btn_db, 0);
        wait_neg(1);
        chk("press_db_after_e6", o_btn_db, 1);
        chk("press_pulse_after_e6", o_press_pulse, 1);
        wait_neg(1);
        chk("press_pulse_width", o_press_pulse, 0);
        wait_neg(4);
        chk("press_once", n_press, 1);
        chk("press_no_release", n_rel, 0);

        // 4a: clean release
        i_button = 1'b0;
        wait_neg(6);
        chk("rel_db_before_e6", o_btn_db, 1);
        wait_neg(1);
        chk("rel_db_after_e6", o_btn_db, 0);
        chk("rel_pulse_after_e6", o_release_pulse, 1);
        wait_neg(1);
        chk("rel_once", n_rel, 1);

        // 3: bouncing press
        wait_neg(5);
        n_press = 0; n_rel = 0;
        foreach (bnc[i]) begin
            i_button = bnc[i];
            wait_neg(1);
        end
        i_button = 1'b1;
        chk("bounce_db", o_btn_db, 0);
        wait_neg(6);
        chk("bounce_db_before", o_btn_db, 0);
        chk("bounce_no_pulse", n_press, 0);
        wait_neg(1);
        chk("bounce_db_after", o_btn_db, 1);
        chk("bounce_pulse", o_press_pulse, 1);

        // 4b: release with a single-cycle glitch back to 1
        wait_neg(3);
        n_rel = 0;
        i_button = 1'b0;
        wait_neg(2);
        i_button = 1'b1;
        wait_neg(1);
        i_button = 1'b0;
        wait_neg(6);
        chk("glitch_db_held", o_btn_db, 1);
        chk("glitch_no_rel", n_rel, 0);
        wait_neg(1);
        chk("glitch_db_after", o_btn_db, 0);
        chk("glitch_rel_pulse", o_release_pulse, 1);

        // 5: long hold
        wait_neg(5);
        n_press = 0; n_long = 0;
        i_button = 1'b1;
        wait_neg(7);
        chk("long_db_up", o_btn_db, 1);
        wait_neg(7);
        chk("long_before", o_long_press, 0);
        wait_neg(1);
        chk("long_at_8", o_long_press, LONG_EN);
        wait_neg(12);
        chk("long_count", n_long, LONG_EN);
        chk("long_db_held", o_btn_db, 1);

        // 6a: reset while pressed clears outputs at once
        rst_n = 1'b0;
        #1;
        chk("rst_db_now", o_btn_db, 0);
        chk("rst_long_now", o_long_press, 0);
        i_button = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(3);

        // 6b: reset in PRESS_WAIT with cnt=2, then requalify from zero
        n_press = 0;
        i_button = 1'b1;
        wait_neg(5);
        rst_n = 1'b0;
        #1;
        chk("rst_pw_db", o_btn_db, 0);
        chk("rst_pw_press", o_press_pulse, 0);
        wait_neg(2);
        chk("rst_pw_no_pulse", n_press, 0);
        rst_n = 1'b1;
        wait_neg(6);
        chk("requal_db_before", o_btn_db, 0);
        chk("requal_no_pulse", n_press, 0);
        wait_neg(1);
        chk("requal_db_after", o_btn_db, 1);
        chk("requal_pulse", o_press_pulse, 1);
        wait_neg(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
